rs_cmd_conditioner: RTL

Upstream command stage for the RS latch: takes three raw, asynchronous, bouncy push-button inputs (set, reset, clear), synchronises and debounces them, and drives the latch's `s`, `r`, `clr` inputs with clean, registered, mutually exclusive commands. The block guarantees that `s` and `r` are never high together, so the latch never enters its s=r=1 state. It also reports dropped or conflicting requests.

---
 rtl/rs_ctrl_pkg.sv | 20 ++
 rtl/debounce_filter.sv | 50 +++++
 rtl/rs_cmd_conditioner.sv | 128 ++++++++++++
 3 files changed

// File: rtl/rs_ctrl_pkg.sv
// Shared types and defaults for the RS latch command conditioner.
// Holds the FSM state enum, parameter defaults and a counter-width helper.
package rs_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPulseS,
    StPulseR,
    StClear
  } rs_state_e;

  localparam int unsigned DefDebounceCycles = 16;
  localparam int unsigned DefPulseCycles    = 1;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/debounce_filter.sv
// Two-flop synchroniser followed by a consecutive-sample debounce filter.
// Outputs the debounced level and a single-cycle pulse aligned with its rising update.
module debounce_filter
  import rs_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic db,
  output logic rise
);

  localparam int unsigned CntW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      sync_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            db_q, db_d;

  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (sync_q[1] != db_q) begin
      if (cnt_q == CntMax) begin
        db_d = ~db_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
      db_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw};
      cnt_q  <= cnt_d;
      db_q   <= db_d;
    end
  end

  assign db   = db_q;
  // Fires in the cycle before db_q rises so the request is latched on the same edge.
  assign rise = db_d & ~db_q;

endmodule

// File: rtl/rs_cmd_conditioner.sv
// Conditions raw set/reset/clear buttons into clean, mutually exclusive latch commands.
// Holds one-deep pending flags, the pulse-width counter and the command FSM.
module rs_cmd_conditioner
  import rs_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
  parameter int unsigned PULSE_CYCLES    = DefPulseCycles
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_set,
  input  logic btn_reset,
  input  logic btn_clr,
  output logic s,
  output logic r,
  output logic clr,
  output logic busy,
  output logic conflict
);

  localparam int unsigned PcntW = cnt_width(PULSE_CYCLES);
  localparam logic [PcntW-1:0] PcntMax = PcntW'(PULSE_CYCLES - 1);

  logic db_set_unused, db_reset_unused, clr_rise_unused;
  logic rise_s, rise_r, db_clr;

  debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_set (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (btn_set),
    .db   (db_set_unused),
    .rise (rise_s)
  );

  debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_reset (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (btn_reset),
    .db   (db_reset_unused),
    .rise (rise_r)
  );

  debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (btn_clr),
    .db   (db_clr),
    .rise (clr_rise_unused)
  );

  rs_state_e        state_q, state_d;
  logic [PcntW-1:0] cnt_q, cnt_d;
  logic             pend_s_q, pend_s_d, pend_r_q, pend_r_d;
  logic             conflict_d;
  logic             s_q, r_q, clr_q, conflict_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_s_d   = pend_s_q | rise_s;
    pend_r_d   = pend_r_q | rise_r;
    conflict_d = (rise_s & pend_s_q) | (rise_r & pend_r_q);
    if (db_clr) begin
      // Clear wins over everything and silently discards queued requests.
      state_d    = StClear;
      cnt_d      = '0;
      pend_s_d   = 1'b0;
      pend_r_d   = 1'b0;
      conflict_d = 1'b0;
    end else begin
      unique case (state_q)
        StClear: state_d = StIdle;
        StIdle: begin
          cnt_d = '0;
          if (rise_s && rise_r) begin
            conflict_d = 1'b1;
            pend_s_d   = pend_s_q;
          end
          if (pend_r_q) begin
            state_d  = StPulseR;
            pend_r_d = 1'b0;
          end else if (pend_s_q) begin
            state_d  = StPulseS;
            pend_s_d = 1'b0;
          end
        end
        StPulseS, StPulseR: begin
          if (cnt_q == PcntMax) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + PcntW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      pend_s_q   <= 1'b0;
      pend_r_q   <= 1'b0;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      clr_q      <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_s_q   <= pend_s_d;
      pend_r_q   <= pend_r_d;
      s_q        <= (state_d == StPulseS);
      r_q        <= (state_d == StPulseR);
      clr_q      <= (state_d == StClear);
      conflict_q <= conflict_d;
    end
  end

  assign s        = s_q;
  assign r        = r_q;
  assign clr      = clr_q;
  assign conflict = conflict_q;
  assign busy     = (state_q == StPulseS) | (state_q == StPulseR) | pend_s_q | pend_r_q;

endmodule
